multicycle_main_control: RTL
============================

Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS-subset datapath.
- Decodes the 6-bit opcode, steps through fetch/decode/execute/memory/writeback states, and drives every datapath enable and mux select.
- Produces the 2-bit AluOp consumed by the ALU control decoder: 00 add, 01 sub, 10 use funct field.
- Stalls on a memory-ready handshake, flags unsupported opcodes, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Op  in  6  opcode field of the instruction register
MemReady  in  1  memory access completes this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero
IorD  out  1  memory address select: 0 PC, 1 ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  register write data: 0 ALUOut, 1 MDR
RegDst  out  1  destination register: 0 rt, 1 rd
RegWrite  out  1  register file write enable
AluSrcA  out  1  ALU A: 0 PC, 1 register A
AluSrcB  out  2  ALU B: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
AluOp  out  2  to ALU control decoder
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
IllegalOp  out  1  one-cycle flag: unsupported opcode
InstrCount  out  CNT_W  retired instruction count
State  out  4  current state, debug

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state and counter: while reset is high, state = FETCH and InstrCount = 0.
- Write enables under reset: PCWrite, PCWriteCond, IRWrite, MemWrite and RegWrite are forced 0 while reset is high. All other outputs show FETCH values: MemRead=1, AluSrcB=01, everything else 0.
- Output decode: outputs are decoded combinationally from state. Exceptions: PCWrite/IRWrite in FETCH and IllegalOp in DECODE also depend on inputs. Any output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are illegal and go to FETCH next cycle.
- FETCH:
  - Outputs: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PCSource=00.
  - PCWrite = IRWrite = MemReady.
  - Holds while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: AluSrcA=0, AluSrcB=11, AluOp=00 (branch target into ALUOut). Next state by Op:
  - 000000 (R-type) -> EXEC
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> IllegalOp=1 this cycle, then FETCH; not counted.
- MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00. Goes to MEMRD for lw, MEMWR for sw. The Op value is re-read here; IR is stable because IRWrite=0.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady, then FETCH.
- EXEC: AluSrcA=1, AluSrcB=00, AluOp=10. Goes to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- ADDIEX: AluSrcA=1, AluSrcB=10, AluOp=00. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- InstrCount:
  - Increments by 1 on the clock edge leaving MEMWB, MEMWR (with MemReady), ALUWB, BRANCH, ADDIWB or JUMP.
  - Wraps from all-ones to 0.
  - Never increments on the illegal-opcode path.
- Reset mid-operation: state returns to FETCH immediately (asynchronously). Pending writes are dropped combinationally and the counter clears.
- Memory handshake: MemReady outside FETCH/MEMRD/MEMWR is ignored.
- Cycle counts with MemReady=1 throughout:
  - lw 5 cycles
  - sw, R-type and addi 4 cycles
  - beq and j 3 cycles
  - each MemReady=0 cycle in a memory state adds one cycle.

Decomposition:
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - AluOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - AluSrcB and PCSource select encodings
  - the 4-bit state encoding.
- The ALU control decoder also imports this package.
- No sub-module: state register, next-state logic, output decode and counter fit in one module.

Test Plan:
- Reset asserted mid-MEMRD, released -> State=0, InstrCount=0, all write enables 0 during reset, FETCH resumes on the first edge after release.
- Op=100011, MemReady=1 throughout -> State sequence 0,1,2,3,4,0; AluOp 00 in MEMADR; RegWrite=1 with MemtoReg=1 in MEMWB; InstrCount 0->1.
- Op=101011, MemReady low 3 cycles in MEMWR -> MemWrite=1 and IorD=1 for 4 cycles, State held at 5, no RegWrite, InstrCount increments once.
- Op=000000 then Op=000100 -> AluOp=10 in EXEC, RegDst=1 in ALUWB; AluOp=01, PCWriteCond=1, PCSource=01 in BRANCH; InstrCount=2.
- Op=111111 -> IllegalOp=1 for exactly one cycle in DECODE, next State=0, InstrCount unchanged.
- Preload via 2^CNT_W-1 retirements (bench CNT_W=4, 16 addi instructions) -> InstrCount wraps 15->0; each addi takes 4 cycles.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path:
// opcodes, ALU operation codes, mux selects and the main FSM state codes.
package mips_ctrl_pkg;

    // Opcode field values of the supported instructions
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // AluOp codes understood by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Main FSM state codes; 12..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } ctrlState_t;

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS-subset datapath: sequences each
// instruction through fetch/decode/execute/memory/writeback, drives all
// datapath enables and selects, flags unsupported opcodes and counts
// retired instructions.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       AluOp,
    output logic [1:0]       PCSource,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       State
);

    ctrlState_t stateReg;
    ctrlState_t stateNext;

    // Ungated write enables; reset masks them so nothing is written while held
    logic pcWriteRaw;
    logic pcWriteCondRaw;
    logic irWriteRaw;
    logic memWriteRaw;
    logic regWriteRaw;
    logic retire;

    // State register, forced to FETCH asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= FETCH;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Retired-instruction counter, bumped on the edge leaving a final state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrCount <= '0;
        end else if (retire) begin
            InstrCount <= InstrCount + CNT_W'(1);
        end
    end

    // Next-state selection and output decode from the current state
    always_comb begin
        stateNext      = FETCH;
        pcWriteRaw     = 1'b0;
        pcWriteCondRaw = 1'b0;
        irWriteRaw     = 1'b0;
        memWriteRaw    = 1'b0;
        regWriteRaw    = 1'b0;
        retire         = 1'b0;
        IorD           = 1'b0;
        MemRead        = 1'b0;
        MemtoReg       = 1'b0;
        RegDst         = 1'b0;
        AluSrcA        = 1'b0;
        AluSrcB        = SRCB_REGB;
        AluOp          = ALUOP_ADD;
        PCSource       = PCSRC_ALU;
        IllegalOp      = 1'b0;
        case (stateReg)
            FETCH: begin
                MemRead    = 1'b1;
                AluSrcB    = SRCB_FOUR;
                pcWriteRaw = MemReady;
                irWriteRaw = MemReady;
                stateNext  = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is computed speculatively into ALUOut here
                AluSrcB = SRCB_IMMSH;
                case (Op)
                    OP_RTYPE:     stateNext = EXEC;
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_BEQ:       stateNext = BRANCH;
                    OP_ADDI:      stateNext = ADDIEX;
                    OP_J:         stateNext = JUMP;
                    default: begin
                        IllegalOp = 1'b1;
                        stateNext = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                // IR is not reloaded after FETCH, so Op is still the lw/sw opcode
                if (Op == OP_LW) begin
                    stateNext = MEMRD;
                end else if (Op == OP_SW) begin
                    stateNext = MEMWR;
                end else begin
                    stateNext = FETCH;
                end
            end
            MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                stateNext = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regWriteRaw = 1'b1;
                MemtoReg    = 1'b1;
                retire      = 1'b1;
            end
            MEMWR: begin
                memWriteRaw = 1'b1;
                IorD        = 1'b1;
                retire      = MemReady;
                stateNext   = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                AluSrcA   = 1'b1;
                AluOp     = ALUOP_FUNCT;
                stateNext = ALUWB;
            end
            ALUWB: begin
                regWriteRaw = 1'b1;
                RegDst      = 1'b1;
                retire      = 1'b1;
            end
            BRANCH: begin
                AluSrcA        = 1'b1;
                AluOp          = ALUOP_SUB;
                pcWriteCondRaw = 1'b1;
                PCSource       = PCSRC_ALUOUT;
                retire         = 1'b1;
            end
            ADDIEX: begin
                AluSrcA   = 1'b1;
                AluSrcB   = SRCB_IMM;
                stateNext = ADDIWB;
            end
            ADDIWB: begin
                regWriteRaw = 1'b1;
                retire      = 1'b1;
            end
            JUMP: begin
                pcWriteRaw = 1'b1;
                PCSource   = PCSRC_JUMP;
                retire     = 1'b1;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    assign PCWrite     = pcWriteRaw & ~reset;
    assign PCWriteCond = pcWriteCondRaw & ~reset;
    assign IRWrite     = irWriteRaw & ~reset;
    assign MemWrite    = memWriteRaw & ~reset;
    assign RegWrite    = regWriteRaw & ~reset;
    assign State       = stateReg;

endmodule
